// File: rtl/imm_decode_stage.sv
// Registered RISC-V immediate-generation stage with a 2-entry skid buffer.
// Optional macro IMM_ZEXT_EN adds the Z-type (CSR zimm) and shamt selects.
module imm_decode_stage #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [2:0]       in_imm_src,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  localparam logic [2:0] SRC_I = 3'b000;
  localparam logic [2:0] SRC_S = 3'b001;
  localparam logic [2:0] SRC_B = 3'b010;
  localparam logic [2:0] SRC_J = 3'b011;
  localparam logic [2:0] SRC_U = 3'b100;
`ifdef IMM_ZEXT_EN
  localparam logic [2:0] SRC_Z     = 3'b101;
  localparam logic [2:0] SRC_SHAMT = 3'b110;
`endif

  state_t            state;
  logic [XLEN-1:0]   sreg_imm;
  logic [TAG_W-1:0]  sreg_tag;
  logic              sreg_illegal;

  logic [XLEN-1:0]   imm_c;
  logic              illegal_c;
  logic [31:0]       imm32_c;
  logic              acc_c;
  logic              pop_c;

  // Opcode bits never feed any immediate field.
  logic unused_opcode;
  assign unused_opcode = ^in_instr[6:0];

  assign acc_c = in_valid && in_ready;
  assign pop_c = out_valid && out_ready;

  // Immediate decode of the offered instruction; sign formats build 32 bits then extend.
  always_comb begin
    imm32_c   = 32'd0;
    imm_c     = '0;
    illegal_c = 1'b0;
    case (in_imm_src)
      SRC_I: begin
        imm32_c = {{20{in_instr[31]}}, in_instr[31:20]};
        imm_c   = XLEN'($signed(imm32_c));
      end
      SRC_S: begin
        imm32_c = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
        imm_c   = XLEN'($signed(imm32_c));
      end
      SRC_B: begin
        imm32_c = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                   in_instr[30:25], in_instr[11:8], 1'b0};
        imm_c   = XLEN'($signed(imm32_c));
      end
      SRC_J: begin
        imm32_c = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                   in_instr[20], in_instr[30:21], 1'b0};
        imm_c   = XLEN'($signed(imm32_c));
      end
      SRC_U: begin
        imm32_c = {in_instr[31:12], 12'd0};
        imm_c   = XLEN'($signed(imm32_c));
      end
`ifdef IMM_ZEXT_EN
      SRC_Z: begin
        imm_c = XLEN'(in_instr[19:15]);
      end
      SRC_SHAMT: begin
        imm_c = XLEN'({(XLEN == 64) & in_instr[25], in_instr[24:20]});
      end
`endif
      default: begin
        imm_c     = '0;
        illegal_c = 1'b1;
      end
    endcase
  end

  // Skid-buffer FSM: OREG drives the outputs, SREG catches one extra entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_EMPTY;
      in_ready     <= 1'b1;
      out_valid    <= 1'b0;
      out_imm      <= '0;
      out_tag      <= '0;
      out_illegal  <= 1'b0;
      sreg_imm     <= '0;
      sreg_tag     <= '0;
      sreg_illegal <= 1'b0;
    end else if (flush) begin
      state     <= ST_EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (acc_c) begin
            out_imm     <= imm_c;
            out_tag     <= in_tag;
            out_illegal <= illegal_c;
            out_valid   <= 1'b1;
            state       <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (acc_c && !pop_c) begin
            sreg_imm     <= imm_c;
            sreg_tag     <= in_tag;
            sreg_illegal <= illegal_c;
            in_ready     <= 1'b0;
            state        <= ST_TWO;
          end else if (acc_c && pop_c) begin
            out_imm     <= imm_c;
            out_tag     <= in_tag;
            out_illegal <= illegal_c;
          end else if (pop_c) begin
            out_valid <= 1'b0;
            state     <= ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (pop_c) begin
            out_imm     <= sreg_imm;
            out_tag     <= sreg_tag;
            out_illegal <= sreg_illegal;
            in_ready    <= 1'b1;
            state       <= ST_ONE;
          end
        end
        default: begin
          state     <= ST_EMPTY;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imm_decode_stage.sv
// Directed self-checking bench for imm_decode_stage (XLEN=32 and XLEN=64 instances).
`timescale 1ns/1ps
module tb_imm_decode_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_valid64;
  logic [31:0] in_instr;
  logic [2:0]  in_imm_src;
  logic [31:0] in_tag;
  logic        out_ready;
  logic        out_ready64;

  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_imm;
  logic [31:0] out_tag;
  logic        out_illegal;

  logic        in_ready64;
  logic        out_valid64;
  logic [63:0] out_imm64;
  logic [31:0] out_tag64;
  logic        out_illegal64;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  imm_decode_stage #(.XLEN(32), .TAG_W(32)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_imm_src(in_imm_src), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_imm(out_imm), .out_tag(out_tag), .out_illegal(out_illegal)
  );

  imm_decode_stage #(.XLEN(64), .TAG_W(32)) dut64 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid64), .in_ready(in_ready64),
    .in_instr(in_instr), .in_imm_src(in_imm_src), .in_tag(in_tag),
    .out_valid(out_valid64), .out_ready(out_ready64),
    .out_imm(out_imm64), .out_tag(out_tag64), .out_illegal(out_illegal64)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs and samples both sit 1ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction to the 32-bit instance for one cycle.
  task automatic push(input logic [31:0] instr, input logic [2:0] src, input logic [31:0] tag);
    in_instr   = instr;
    in_imm_src = src;
    in_tag     = tag;
    in_valid   = 1'b1;
    step();
    in_valid   = 1'b0;
  endtask

  // Single accept with out_ready high, checked one cycle later.
  task automatic send_chk(input string name, input logic [31:0] instr, input logic [2:0] src,
                          input logic [31:0] tag, input logic [31:0] exp_imm, input logic exp_ill);
    push(instr, src, tag);
    check({name, "_valid"},   64'(out_valid),   64'd1);
    check({name, "_imm"},     64'(out_imm),     64'(exp_imm));
    check({name, "_illegal"}, 64'(out_illegal), 64'(exp_ill));
    check({name, "_tag"},     64'(out_tag),     64'(tag));
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_valid64 = 1'b0;
    in_instr = 32'd0; in_imm_src = 3'd0; in_tag = 32'd0;
    out_ready = 1'b1; out_ready64 = 1'b1;
    #1;
    step();
    step();
    reset = 1'b0;

    check("rst_valid",   64'(out_valid),   64'd0);
    check("rst_ready",   64'(in_ready),    64'd1);
    check("rst_imm",     64'(out_imm),     64'd0);
    check("rst_tag",     64'(out_tag),     64'd0);
    check("rst_illegal", 64'(out_illegal), 64'd0);

    // Format decode with out_ready high, back-to-back accepts.
    send_chk("fmt_i", 32'hFFF00093, 3'b000, 32'h100, 32'hFFFFFFFF, 1'b0);
    send_chk("fmt_s", 32'hFE20AE23, 3'b001, 32'h104, 32'hFFFFFFFC, 1'b0);
    send_chk("fmt_b", 32'h00000463, 3'b010, 32'h108, 32'h00000008, 1'b0);
    send_chk("fmt_j", 32'hFFDFF06F, 3'b011, 32'h10C, 32'hFFFFFFFC, 1'b0);
    send_chk("fmt_u", 32'h123450B7, 3'b100, 32'h110, 32'h12345000, 1'b0);
`ifdef IMM_ZEXT_EN
    send_chk("fmt_z",     32'h000FD073, 3'b101, 32'h114, 32'h0000001F, 1'b0);
    send_chk("fmt_shamt", 32'h03F0D093, 3'b110, 32'h118, 32'h0000001F, 1'b0);
`else
    send_chk("fmt_z",     32'h000FD073, 3'b101, 32'h114, 32'h00000000, 1'b1);
    send_chk("fmt_shamt", 32'h03F0D093, 3'b110, 32'h118, 32'h00000000, 1'b1);
`endif
    send_chk("fmt_111", 32'hFFFFFFFF, 3'b111, 32'h11C, 32'h00000000, 1'b1);
    step();
    check("drain_valid", 64'(out_valid), 64'd0);

    // Backpressure: two entries fill the skid buffer.
    out_ready = 1'b0;
    push(32'h00100093, 3'b000, 32'd1);
    check("bp1_ready", 64'(in_ready), 64'd1);
    push(32'h00200093, 3'b000, 32'd2);
    check("bp2_ready", 64'(in_ready), 64'd0);
    check("bp2_tag",   64'(out_tag),  64'd1);
    step();
    check("bp_hold_tag", 64'(out_tag), 64'd1);
    check("bp_hold_imm", 64'(out_imm), 64'd1);
    out_ready = 1'b1;
    step();
    check("pop1_valid", 64'(out_valid), 64'd1);
    check("pop1_tag",   64'(out_tag),   64'd2);
    check("pop1_imm",   64'(out_imm),   64'd2);
    check("pop1_ready", 64'(in_ready),  64'd1);
    step();
    check("pop2_valid", 64'(out_valid), 64'd0);

    // Flush with two entries held and an input offered.
    out_ready = 1'b0;
    push(32'h00300093, 3'b000, 32'd3);
    push(32'h00400093, 3'b000, 32'd4);
    flush = 1'b1;
    in_valid = 1'b1; in_tag = 32'd5; in_instr = 32'h00500093;
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("fl2_valid", 64'(out_valid), 64'd0);
    check("fl2_ready", 64'(in_ready),  64'd1);
    out_ready = 1'b1;
    step();
    check("fl2_drop", 64'(out_valid), 64'd0);

    // Flush in ONE with an acceptable input: the offered entry is dropped.
    out_ready = 1'b0;
    push(32'h00600093, 3'b000, 32'd6);
    flush = 1'b1;
    in_valid = 1'b1; in_tag = 32'd7; in_instr = 32'h00700093;
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("fl1_valid", 64'(out_valid), 64'd0);
    check("fl1_ready", 64'(in_ready),  64'd1);
    step();
    check("fl1_drop", 64'(out_valid), 64'd0);

    // Reset while holding two entries.
    push(32'h00800093, 3'b000, 32'd8);
    push(32'h00900093, 3'b000, 32'd9);
    check("pre_rst_ready", 64'(in_ready), 64'd0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rst2_valid", 64'(out_valid), 64'd0);
    check("rst2_ready", 64'(in_ready),  64'd1);
    check("rst2_imm",   64'(out_imm),   64'd0);
    check("rst2_tag",   64'(out_tag),   64'd0);
    out_ready = 1'b1;
    send_chk("post_rst", 32'h7FF00093, 3'b000, 32'd10, 32'h000007FF, 1'b0);
    step();

    // XLEN=64 instance.
    in_instr = 32'h800000B7; in_imm_src = 3'b100; in_tag = 32'h64; in_valid64 = 1'b1;
    step();
    check("x64_u_valid", 64'(out_valid64), 64'd1);
    check("x64_u_imm",   out_imm64,        64'hFFFFFFFF80000000);
    in_instr = 32'h7FF00093; in_imm_src = 3'b000; in_tag = 32'h65;
    step();
    in_valid64 = 1'b0;
    check("x64_i_imm", out_imm64,        64'h00000000000007FF);
    check("x64_i_tag", 64'(out_tag64),   64'h65);
    check("x64_i_ill", 64'(out_illegal64), 64'd0);
    in_instr = 32'h0000D073; in_imm_src = 3'b111; in_valid64 = 1'b1;
    step();
    in_valid64 = 1'b0;
    check("x64_111_imm", out_imm64,            64'd0);
    check("x64_111_ill", 64'(out_illegal64),   64'd1);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
